// File: rtl/wrf_fec_loss_emulator.sv
// Frame-loss emulator between the FEC encoder and the fabric loopback: deletes
// chosen frames of each 4-frame group by per-index mask or LFSR threshold.
module wrf_fec_loss_emulator #(
   parameter logic [15:0] g_lfsr_init = 16'hACE1
) (
   input  logic        clk_i,
   input  logic        rst_n_i,
   // fabric sink (from encoder)
   input  logic        snk_cyc,
   input  logic        snk_stb,
   input  logic        snk_we,
   input  logic [1:0]  snk_sel,
   input  logic [1:0]  snk_adr,
   input  logic [15:0] snk_dat,
   output logic        snk_ack,
   output logic        snk_stall,
   // fabric source (toward loopback)
   output logic        src_cyc,
   output logic        src_stb,
   output logic        src_we,
   output logic [1:0]  src_sel,
   output logic [1:0]  src_adr,
   output logic [15:0] src_dat,
   input  logic        src_ack,
   input  logic        src_stall,
   // configuration slave
   input  logic        wb_cyc,
   input  logic        wb_stb,
   input  logic        wb_we,
   input  logic [3:0]  wb_sel,
   input  logic [31:0] wb_adr,
   input  logic [31:0] wb_dat_i,
   output logic [31:0] wb_dat_o,
   output logic        wb_ack,
   output logic        wb_stall
);

   localparam int unsigned CNT_W  = 32;
   localparam int unsigned LFSR_W = 16;
   localparam int unsigned GRP_W  = 2;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_FWD  = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_prev_cyc;
   logic                r_drop_ack;
   logic                r_en;
   logic                r_mode;
   logic [3:0]          r_shadow;
   logic [3:0]          r_mask;
   logic [LFSR_W-1:0]   r_thresh;
   logic [LFSR_W-1:0]   r_lfsr;
   logic [CNT_W-1:0]    r_frames_in;
   logic [CNT_W-1:0]    r_frames_drop;
   logic [GRP_W-1:0]    r_gidx;
   logic                r_wb_ack;
   logic [31:0]         r_wb_dat;

   logic                w_start;
   logic                w_end;
   logic [3:0]          w_mask_eff;
   logic                w_drop;
   logic                w_pass;
   logic                w_dropping;
   logic [LFSR_W-1:0]   w_lfsr_next;
   logic                w_wb_req;
   logic                w_wb_wr;
   logic [2:0]          w_wb_idx;
   logic                w_ctrl_wr;
   logic                w_cnt_clr;
   logic                w_grp_rst;
   logic [31:0]         w_rd_dat;
   logic                w_unused_wb;

   // Frame boundaries; r_prev_cyc resets high so a frame still in flight at
   // reset release is not mistaken for a new frame start.
   assign w_start    = snk_cyc & ~r_prev_cyc & (r_state == ST_IDLE);
   assign w_end      = ~snk_cyc & (r_state != ST_IDLE);

   // At an index-0 start the shadow mask becomes active in that same cycle.
   assign w_mask_eff = (r_gidx == GRP_W'(0)) ? r_shadow : r_mask;
   assign w_drop     = r_en & (r_mode ? (r_lfsr < r_thresh) : w_mask_eff[r_gidx]);

   assign w_pass     = (r_state == ST_FWD)  | (w_start & ~w_drop);
   assign w_dropping = (r_state == ST_DROP) | (w_start &  w_drop);

   assign w_lfsr_next = {r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5], r_lfsr[LFSR_W-1:1]};

   assign w_wb_req  = wb_cyc & wb_stb;
   assign w_wb_wr   = w_wb_req & wb_we;
   assign w_wb_idx  = wb_adr[4:2];
   assign w_ctrl_wr = w_wb_wr & (w_wb_idx == 3'd0);
   assign w_cnt_clr = w_ctrl_wr & wb_dat_i[2];
   assign w_grp_rst = w_ctrl_wr & wb_dat_i[3];

   assign w_unused_wb = ^{wb_sel, wb_adr[31:5], wb_adr[1:0], wb_dat_i[31:16]};

   // Zero-latency forward path; a dropped frame is swallowed and self-acked.
   assign src_cyc   = w_pass & snk_cyc;
   assign src_stb   = w_pass & snk_stb;
   assign src_we    = w_pass & snk_we;
   assign src_sel   = w_pass ? snk_sel : 2'b00;
   assign src_adr   = w_pass ? snk_adr : 2'b00;
   assign src_dat   = w_pass ? snk_dat : 16'h0000;
   assign snk_stall = w_pass & src_stall;
   assign snk_ack   = w_pass ? src_ack : r_drop_ack;

   assign wb_ack    = r_wb_ack;
   assign wb_dat_o  = r_wb_dat;
   assign wb_stall  = 1'b0;

   always_comb begin
      w_rd_dat = '0;
      case (w_wb_idx)
         3'd0:    w_rd_dat = {30'd0, r_mode, r_en};
         3'd1:    w_rd_dat = {28'd0, r_shadow};
         3'd2:    w_rd_dat = {16'd0, r_thresh};
         3'd3:    w_rd_dat = {16'd0, r_lfsr};
         3'd4:    w_rd_dat = r_frames_in;
         3'd5:    w_rd_dat = r_frames_drop;
         3'd6:    w_rd_dat = {30'd0, r_gidx};
         default: w_rd_dat = '0;
      endcase
   end

   // Frame state machine and dropped-frame ack
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_state    <= ST_IDLE;
         r_prev_cyc <= 1'b1;
         r_drop_ack <= 1'b0;
      end else begin
         r_prev_cyc <= snk_cyc;
         r_drop_ack <= w_dropping & snk_cyc & snk_stb;
         if (w_start)
            r_state <= w_drop ? ST_DROP : ST_FWD;
         else if (w_end)
            r_state <= ST_IDLE;
      end
   end

   // Configuration, group index, LFSR and statistics
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_en          <= 1'b0;
         r_mode        <= 1'b0;
         r_shadow      <= '0;
         r_mask        <= '0;
         r_thresh      <= '0;
         r_lfsr        <= g_lfsr_init;
         r_frames_in   <= '0;
         r_frames_drop <= '0;
         r_gidx        <= '0;
      end else begin
         if (w_ctrl_wr) begin
            r_en   <= wb_dat_i[0];
            r_mode <= wb_dat_i[1];
         end
         if (w_wb_wr && w_wb_idx == 3'd1)
            r_shadow <= wb_dat_i[3:0];
         if (w_wb_wr && w_wb_idx == 3'd2)
            r_thresh <= wb_dat_i[15:0];

         if (w_start && r_gidx == GRP_W'(0))
            r_mask <= r_shadow;

         if (w_wb_wr && w_wb_idx == 3'd3)
            r_lfsr <= (wb_dat_i[15:0] == 16'd0) ? g_lfsr_init : wb_dat_i[15:0];
         else if (w_start)
            r_lfsr <= w_lfsr_next;

         if (w_grp_rst)
            r_gidx <= '0;
         else if (w_end)
            r_gidx <= r_gidx + GRP_W'(1);

         if (w_cnt_clr)
            r_frames_in <= '0;
         else if (w_start && r_frames_in != CNT_MAX)
            r_frames_in <= r_frames_in + CNT_W'(1);

         if (w_cnt_clr)
            r_frames_drop <= '0;
         else if (w_start && w_drop && r_frames_drop != CNT_MAX)
            r_frames_drop <= r_frames_drop + CNT_W'(1);
      end
   end

   // Wishbone slave: single-cycle ack, read data captured with the request
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wb_ack <= 1'b0;
         r_wb_dat <= '0;
      end else begin
         r_wb_ack <= w_wb_req;
         r_wb_dat <= (w_wb_req & ~wb_we) ? w_rd_dat : '0;
      end
   end

endmodule

// File: tb/tb_wrf_fec_loss_emulator.sv
// Self-checking bench for wrf_fec_loss_emulator: directed phases with random
// payloads/stalls, checked against a frame-level model of the loss rules.
module tb_wrf_fec_loss_emulator;

   logic        clk_i = 1'b0;
   logic        rst_n_i;
   logic        snk_cyc, snk_stb, snk_we;
   logic [1:0]  snk_sel, snk_adr;
   logic [15:0] snk_dat;
   logic        snk_ack, snk_stall;
   logic        src_cyc, src_stb, src_we;
   logic [1:0]  src_sel, src_adr;
   logic [15:0] src_dat;
   logic        src_ack, src_stall;
   logic        wb_cyc, wb_stb, wb_we;
   logic [3:0]  wb_sel;
   logic [31:0] wb_adr, wb_dat_i, wb_dat_o;
   logic        wb_ack, wb_stall;

   always #5 clk_i = ~clk_i;

   wrf_fec_loss_emulator dut (
      .clk_i(clk_i), .rst_n_i(rst_n_i),
      .snk_cyc(snk_cyc), .snk_stb(snk_stb), .snk_we(snk_we), .snk_sel(snk_sel),
      .snk_adr(snk_adr), .snk_dat(snk_dat), .snk_ack(snk_ack), .snk_stall(snk_stall),
      .src_cyc(src_cyc), .src_stb(src_stb), .src_we(src_we), .src_sel(src_sel),
      .src_adr(src_adr), .src_dat(src_dat), .src_ack(src_ack), .src_stall(src_stall),
      .wb_cyc(wb_cyc), .wb_stb(wb_stb), .wb_we(wb_we), .wb_sel(wb_sel),
      .wb_adr(wb_adr), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
      .wb_ack(wb_ack), .wb_stall(wb_stall)
   );

   int checks   = 0;
   int failures = 0;

   // Frame-level reference model
   bit          m_en, m_mode;
   logic [3:0]  m_shadow, m_mask;
   logic [15:0] m_thresh, m_lfsr;
   logic [31:0] m_in, m_drop;
   int          m_gidx;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [15:0] lfsr_step(input logic [15:0] v);
      int   exps[4] = '{16, 14, 13, 11};
      logic fb = 1'b0;
      foreach (exps[i]) fb ^= v[16 - exps[i]];
      return {fb, v[15:1]};
   endfunction

   task automatic model_reset();
      m_en = 0; m_mode = 0; m_shadow = '0; m_mask = '0; m_thresh = '0;
      m_lfsr = 16'hACE1; m_in = '0; m_drop = '0; m_gidx = 0;
   endtask

   task automatic model_write(input int idx, input logic [31:0] v);
      case (idx)
         0: begin
            m_en = v[0]; m_mode = v[1];
            if (v[2]) begin m_in = '0; m_drop = '0; end
            if (v[3]) m_gidx = 0;
         end
         1: m_shadow = v[3:0];
         2: m_thresh = v[15:0];
         3: m_lfsr = (v[15:0] == 16'd0) ? 16'hACE1 : v[15:0];
         default: ;
      endcase
   endtask

   function automatic logic [31:0] model_read(input int idx);
      case (idx)
         0: return {30'd0, m_mode, m_en};
         1: return {28'd0, m_shadow};
         2: return {16'd0, m_thresh};
         3: return {16'd0, m_lfsr};
         4: return m_in;
         5: return m_drop;
         6: return 32'(m_gidx);
         default: return 32'd0;
      endcase
   endfunction

   task automatic model_start(output bit drop);
      if (m_gidx == 0) m_mask = m_shadow;
      drop = m_en && (m_mode ? (m_lfsr < m_thresh) : m_mask[m_gidx]);
      if (m_in != 32'hFFFF_FFFF) m_in++;
      if (drop && m_drop != 32'hFFFF_FFFF) m_drop++;
      m_lfsr = lfsr_step(m_lfsr);
   endtask

   task automatic wb_write(input int idx, input logic [31:0] val);
      @(negedge clk_i);
      wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'(idx) << 2; wb_dat_i = val;
      model_write(idx, val);
      #1 check("wb_stall", 32'(wb_stall), 32'd0);
      @(negedge clk_i);
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
      #1 check("wb_wr_ack", 32'(wb_ack), 32'd1);
   endtask

   task automatic wb_read_check(input string tag, input int idx, input logic [31:0] exp);
      @(negedge clk_i);
      wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_adr = 32'(idx) << 2;
      @(negedge clk_i);
      wb_cyc = 0; wb_stb = 0;
      #1 check({tag, "_ack"}, 32'(wb_ack), 32'd1);
      check(tag, wb_dat_o, exp);
   endtask

   task automatic read_all_vs_model(input string tag);
      for (int i = 0; i < 8; i++)
         wb_read_check($sformatf("%s_reg%0d", tag, i), i, model_read(i));
   endtask

   // One frame on the sink; the bench also plays the loopback slave on src.
   task automatic run_frame(input int nwords, input bit rnd_stall, input int wb_at,
                            input int wb_idx, input logic [31:0] wb_val,
                            input int rst_at, output bit fwd_seen);
      logic [15:0] words[$];
      logic [15:0] rx[$];
      bit exp_drop, pend_src, pend_drop, aborted;
      int sent, acks, cyc;
      fwd_seen = 0; pend_src = 0; pend_drop = 0; aborted = 0;
      sent = 0; acks = 0; cyc = 0;
      for (int i = 0; i < nwords; i++) words.push_back(16'($urandom));
      model_start(exp_drop);
      while (sent < nwords) begin
         @(negedge clk_i);
         snk_cyc = 1; snk_stb = 1; snk_we = 1'($urandom); snk_sel = 2'($urandom);
         snk_adr = 2'($urandom); snk_dat = words[sent];
         src_stall = (rnd_stall && cyc < 4 * nwords + 8) ? 1'($urandom) : 1'b0;
         src_ack = pend_src;
         if (cyc == wb_at) begin
            wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_adr = 32'(wb_idx) << 2; wb_dat_i = wb_val;
            model_write(wb_idx, wb_val);
         end else begin
            wb_cyc = 0; wb_stb = 0; wb_we = 0;
         end
         if (cyc == rst_at) begin
            rst_n_i = 0;
            #1;
            check("rst_src_cyc", 32'(src_cyc), 32'd0);
            check("rst_src_stb", 32'(src_stb), 32'd0);
            check("rst_snk_ack", 32'(snk_ack), 32'd0);
            aborted = 1;
            break;
         end
         #1;
         if (src_cyc === 1'b1) fwd_seen = 1;
         if (exp_drop) begin
            check("drop_src_cyc", 32'(src_cyc), 32'd0);
            check("drop_src_stb", 32'(src_stb), 32'd0);
            check("drop_snk_stall", 32'(snk_stall), 32'd0);
            check("drop_ack", 32'(snk_ack), 32'(pend_drop));
         end else begin
            check("fwd_src_cyc", 32'(src_cyc), 32'd1);
            check("fwd_src_stb", 32'(src_stb), 32'd1);
            check("fwd_dat", 32'(src_dat), 32'(snk_dat));
            check("fwd_ctl", 32'({src_we, src_sel, src_adr}), 32'({snk_we, snk_sel, snk_adr}));
            check("fwd_stall", 32'(snk_stall), 32'(src_stall));
            check("fwd_ack", 32'(snk_ack), 32'(src_ack));
            if (src_stb === 1'b1 && !src_stall) rx.push_back(src_dat);
         end
         if (snk_ack === 1'b1) acks++;
         pend_src  = !exp_drop && !src_stall;
         pend_drop = exp_drop;
         if (exp_drop || !src_stall) sent++;
         cyc++;
      end
      if (aborted) begin
         snk_cyc = 0; snk_stb = 0; src_ack = 0; src_stall = 0; wb_cyc = 0; wb_stb = 0;
         @(negedge clk_i);
         rst_n_i = 1;
         model_reset();
         return;
      end
      // Falling-cyc cycle: the last ack of the frame is still due here.
      @(negedge clk_i);
      snk_cyc = 0; snk_stb = 0; src_stall = 0; src_ack = pend_src;
      wb_cyc = 0; wb_stb = 0; wb_we = 0;
      #1;
      check("end_ack", 32'(snk_ack), 32'(exp_drop ? pend_drop : pend_src));
      check("end_src_cyc", 32'(src_cyc), 32'd0);
      if (snk_ack === 1'b1) acks++;
      m_gidx = (m_gidx + 1) % 4;
      check("ack_count", 32'(acks), 32'(nwords));
      if (!exp_drop) begin
         check("rx_count", 32'(rx.size()), 32'(nwords));
         foreach (rx[i]) if (i < nwords) check($sformatf("rx_word%0d", i), 32'(rx[i]), 32'(words[i]));
      end
   endtask

   initial begin
      bit         fwd;
      logic [7:0] pat_exp;
      logic [3:0] grp_exp;
      rst_n_i = 0;
      snk_cyc = 0; snk_stb = 0; snk_we = 0; snk_sel = '0; snk_adr = '0; snk_dat = '0;
      src_ack = 0; src_stall = 0;
      wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_sel = 4'hF; wb_adr = '0; wb_dat_i = '0;
      model_reset();
      repeat (3) @(negedge clk_i);
      #1;
      check("reset_src_cyc", 32'(src_cyc), 32'd0);
      check("reset_snk_ack", 32'(snk_ack), 32'd0);
      check("reset_snk_stall", 32'(snk_stall), 32'd0);
      check("reset_wb_ack", 32'(wb_ack), 32'd0);
      check("reset_wb_dat", wb_dat_o, 32'd0);
      @(negedge clk_i);
      rst_n_i = 1;
      read_all_vs_model("reset");
      wb_read_check("reset_seed", 3, 32'h0000_ACE1);

      // Pattern drop: mask 0x6 keeps group indices 0 and 3
      wb_write(1, 32'h6);
      wb_write(0, 32'h1);
      pat_exp = 8'b1001_1001;
      for (int i = 0; i < 8; i++) begin
         run_frame($urandom_range(1, 8), 0, -1, 0, 0, -1, fwd);
         check($sformatf("pat_fwd%0d", i), 32'(fwd), 32'(pat_exp[i]));
      end
      wb_read_check("pat_in", 4, 32'd8);
      wb_read_check("pat_drop", 5, 32'd4);
      wb_read_check("pat_gidx", 6, 32'd0);

      // Long dropped frame with a noisy src_stall that must not leak through
      wb_write(1, 32'h1);
      run_frame(300, 1, -1, 0, 0, -1, fwd);
      check("long_drop_fwd", 32'(fwd), 32'd0);
      run_frame(5, 0, -1, 0, 0, -1, fwd);
      check("idx1_fwd", 32'(fwd), 32'd1);

      // Mid-group pattern write only takes effect from the next index-0 frame
      wb_read_check("mid_gidx", 6, 32'd2);
      wb_write(1, 32'hF);
      grp_exp = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         run_frame($urandom_range(2, 6), 1, -1, 0, 0, -1, fwd);
         check($sformatf("mid_fwd%0d", i), 32'(fwd), 32'(grp_exp[i]));
      end

      // GRP_RST and EN=0 written inside dropped frames
      run_frame(10, 0, 3, 0, 32'h9, -1, fwd);
      check("grst_fwd", 32'(fwd), 32'd0);
      wb_read_check("grst_gidx", 6, 32'd1);
      run_frame(10, 0, 2, 0, 32'h0, -1, fwd);
      check("latched_drop_fwd", 32'(fwd), 32'd0);
      run_frame(6, 0, -1, 0, 0, -1, fwd);
      check("disabled_fwd", 32'(fwd), 32'd1);

      // CNT_CLR landing on a frame-start cycle
      run_frame(4, 0, 0, 0, 32'h5, -1, fwd);
      check("clr_fwd", 32'(fwd), 32'd1);
      wb_read_check("clr_in", 4, 32'd0);
      wb_read_check("clr_drop", 5, 32'd0);

      // Random mode: zero seed and zero threshold never drop
      wb_write(3, 32'h0);
      wb_write(2, 32'h0);
      wb_write(0, 32'h3);
      wb_read_check("seed0", 3, 32'h0000_ACE1);
      for (int i = 0; i < 8; i++) begin
         run_frame($urandom_range(1, 6), 1, -1, 0, 0, -1, fwd);
         check($sformatf("thr0_fwd%0d", i), 32'(fwd), 32'd1);
      end
      wb_read_check("thr0_drop", 5, 32'd0);
      wb_write(2, 32'hFFFF);
      wb_write(0, 32'h7);
      for (int i = 0; i < 16; i++) run_frame($urandom_range(1, 4), 0, -1, 0, 0, -1, fwd);
      wb_read_check("thrmax_in", 4, 32'd16);
      wb_read_check("thrmax_drop", 5, model_read(5));
      wb_read_check("thrmax_lfsr", 3, model_read(3));

      // Random seed/threshold, then random pattern, all against the model
      wb_write(3, 32'($urandom) & 32'hFFFF);
      wb_write(2, 32'($urandom) & 32'hFFFF);
      for (int i = 0; i < 24; i++) run_frame($urandom_range(1, 12), 1, -1, 0, 0, -1, fwd);
      read_all_vs_model("rand");
      wb_write(1, 32'($urandom_range(0, 15)));
      wb_write(0, 32'h1);
      for (int i = 0; i < 12; i++) run_frame($urandom_range(1, 12), 1, -1, 0, 0, -1, fwd);
      read_all_vs_model("rpat");

      // Forwarding under random stall
      wb_write(0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         run_frame(40, 1, -1, 0, 0, -1, fwd);
         check($sformatf("stall_fwd%0d", i), 32'(fwd), 32'd1);
      end

      // Reset in the middle of a forwarded frame
      run_frame(80, 0, -1, 0, 0, 50, fwd);
      read_all_vs_model("postrst");
      wb_read_check("postrst_seed", 3, 32'h0000_ACE1);
      run_frame(5, 0, -1, 0, 0, -1, fwd);
      check("postrst_fwd", 32'(fwd), 32'd1);
      wb_read_check("postrst_in", 4, 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
